// File: rtl/maxnet_sequencer.sv
// Maxnet winner-take-all controller: iterates x[i] <- relu(x[i] - eps*(S - x[i]))
// over N FP32 neurons using one shared external combinational adder and multiplier.
module maxnet_sequencer #(
  parameter int N        = 4,
  parameter int XLEN     = 32,
  parameter int MAX_ITER = 64,
  parameter int ITER_W   = 8,
  localparam int IDX_W   = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N*XLEN-1:0]   data_in,
  input  logic [XLEN-1:0]     eps,
  output logic [XLEN-1:0]     add_a,
  output logic [XLEN-1:0]     add_b,
  input  logic [XLEN-1:0]     add_result,
  output logic [XLEN-1:0]     mul_a,
  output logic [XLEN-1:0]     mul_b,
  input  logic [XLEN-1:0]     mul_result,
  output logic                busy,
  output logic                done,
  output logic [IDX_W-1:0]    winner,
  output logic                winner_valid,
  output logic                timeout,
  output logic [ITER_W-1:0]   iter_count,
  output logic [N*XLEN-1:0]   values
);

  typedef enum logic [2:0] {IDLE, SUM, DIFF, UPD, FIN} state_t;

  state_t            state;
  logic [XLEN-1:0]   x [N];
  logic [XLEN-1:0]   eps_r, acc, s, d;
  logic [IDX_W-1:0]  idx, last_nz;
  logic [IDX_W:0]    nz;

  logic [XLEN-1:0]   xi, acc_next;
  logic [IDX_W:0]    nz_next;
  logic [ITER_W-1:0] iter_next;
  logic              xi_nz, last, t_zero, relu, step;

  // Negative initial activations are clamped to zero on load.
  function automatic logic [XLEN-1:0] clamp_neg(input logic [XLEN-1:0] w);
    return w[XLEN-1] ? '0 : w;
  endfunction

  assign xi        = x[idx];
  assign xi_nz     = (xi != '0);
  assign last      = (idx == IDX_W'(N-1));
  assign t_zero    = (mul_result == '0);
  assign relu      = (mul_result[XLEN-2:0] >= xi[XLEN-2:0]);
  assign step      = ((state == DIFF) && !xi_nz) || (state == UPD);
  assign nz_next   = nz + {{IDX_W{1'b0}}, xi_nz};
  assign iter_next = iter_count + ITER_W'(1);

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign values[g*XLEN +: XLEN] = x[g];
  end

  always_comb begin
    acc_next = acc;
    if (xi_nz)
      acc_next = (acc == '0) ? xi : add_result;
  end

  // Multiplier operands depend only on registered state, so the adder path
  // below may depend on mul_result without forming a loop.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state == UPD) begin
      mul_a = eps_r;
      mul_b = d;
    end
  end

  // The shared adder never sees a zero operand: zero cases are bypassed.
  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state)
      SUM: if (xi_nz && (acc != '0)) begin
        add_a = acc;
        add_b = xi;
      end
      DIFF: if (xi_nz) begin
        add_a = s;
        add_b = {~xi[XLEN-1], xi[XLEN-2:0]};
      end
      UPD: if (!t_zero && !relu) begin
        add_a = xi;
        add_b = {1'b1, mul_result[XLEN-2:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      for (int k = 0; k < N; k++) x[k] <= '0;
      eps_r        <= '0;
      acc          <= '0;
      s            <= '0;
      d            <= '0;
      idx          <= '0;
      last_nz      <= '0;
      nz           <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      winner       <= '0;
      winner_valid <= 1'b0;
      timeout      <= 1'b0;
      iter_count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          for (int k = 0; k < N; k++) x[k] <= clamp_neg(data_in[k*XLEN +: XLEN]);
          eps_r        <= eps;
          iter_count   <= '0;
          winner_valid <= 1'b0;
          timeout      <= 1'b0;
          idx          <= '0;
          acc          <= '0;
          nz           <= '0;
          busy         <= 1'b1;
          state        <= SUM;
        end
        SUM: begin
          acc <= acc_next;
          nz  <= nz_next;
          if (xi_nz) last_nz <= idx;
          if (last) begin
            idx <= '0;
            if (nz_next <= (IDX_W+1)'(1)) begin
              winner_valid <= (nz_next == (IDX_W+1)'(1));
              if (nz_next == (IDX_W+1)'(1)) winner <= xi_nz ? idx : last_nz;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              s     <= acc_next;
              state <= DIFF;
            end
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DIFF: if (xi_nz) begin
          d     <= add_result;
          state <= UPD;
        end
        UPD: if (!t_zero) x[idx] <= relu ? '0 : add_result;
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Advance to the next neuron, or close the pass.
      if (step) begin
        if (last) begin
          idx        <= '0;
          iter_count <= iter_next;
          if (iter_next == ITER_W'(MAX_ITER)) begin
            timeout      <= 1'b1;
            winner_valid <= 1'b0;
            done         <= 1'b1;
            state        <= FIN;
          end else begin
            acc   <= '0;
            nz    <= '0;
            state <= SUM;
          end
        end else begin
          idx   <= idx + IDX_W'(1);
          state <= DIFF;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxnet_sequencer.sv
// Bench for maxnet_sequencer: FP32 adder/multiplier models, directed and random
// runs compared against an array-level Maxnet reference model.
module tb_maxnet_sequencer;
  localparam int N = 4;
  localparam int XLEN = 32;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start4 = 1'b0;
  logic [N*XLEN-1:0] data_in = '0;
  logic [31:0] eps = '0;

  logic [31:0] add_a, add_b, add_result, mul_a, mul_b, mul_result;
  logic busy, done, winner_valid, timeout;
  logic [1:0] winner;
  logic [7:0] iter_count;
  logic [N*XLEN-1:0] values;

  logic [31:0] add_a4, add_b4, add_result4, mul_a4, mul_b4, mul_result4;
  logic busy4, done4, winner_valid4, timeout4;
  logic [1:0] winner4;
  logic [7:0] iter_count4;
  logic [N*XLEN-1:0] values4;

  int n_assert = 0;
  int n_fail = 0;
  int add_used = 0;

  always #5 clk = ~clk;

  maxnet_sequencer #(.N(N), .XLEN(XLEN), .MAX_ITER(64), .ITER_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in), .eps(eps),
    .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .busy(busy), .done(done), .winner(winner), .winner_valid(winner_valid),
    .timeout(timeout), .iter_count(iter_count), .values(values));

  maxnet_sequencer #(.N(N), .XLEN(XLEN), .MAX_ITER(4), .ITER_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .data_in(data_in), .eps(eps),
    .add_a(add_a4), .add_b(add_b4), .add_result(add_result4),
    .mul_a(mul_a4), .mul_b(mul_b4), .mul_result(mul_result4),
    .busy(busy4), .done(done4), .winner(winner4), .winner_valid(winner_valid4),
    .timeout(timeout4), .iter_count(iter_count4), .values(values4));

  function automatic real f2r(input logic [31:0] b);
    logic [63:0] q;
    if (b[30:0] == 31'd0) return 0.0;
    q = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
    return $bitstoreal(q);
  endfunction

  // Round-to-nearest-even from double; operands stay in the normal range.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] q;
    logic [52:0] m;
    logic [24:0] m24;
    int e;
    q = $realtobits(r);
    if (q[62:0] == 63'd0) return 32'd0;
    e = int'(q[62:52]) - 896;
    m = {1'b1, q[51:0]};
    m24 = {1'b0, m[52:29]};
    if (m[28] && ((|m[27:0]) || m24[0])) m24 = m24 + 25'd1;
    if (m24[24]) begin
      e = e + 1;
      m24 = m24 >> 1;
    end
    return {q[63], 8'(e), m24[22:0]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  always_comb mul_result  = fmul(mul_a, mul_b);
  always_comb add_result  = fadd(add_a, add_b);
  always_comb mul_result4 = fmul(mul_a4, mul_b4);
  always_comb add_result4 = fadd(add_a4, add_b4);

  // The adder must never see exactly one zero operand.
  always @(negedge clk) begin
    n_assert++;
    assert (((add_a == 32'd0) == (add_b == 32'd0)) && ((add_a4 == 32'd0) == (add_b4 == 32'd0)))
    else begin
      n_fail++;
      $error("FAIL adder_zero_operand: got a=%h b=%h a4=%h b4=%h want both-or-neither zero",
             add_a, add_b, add_a4, add_b4);
    end
    if (add_a != 32'd0 && add_b != 32'd0) add_used++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: Maxnet passes on plain arrays; lat counts edges from start to done.
  task automatic model(input logic [31:0] din [N], input logic [31:0] e, input int maxit,
                       output logic [31:0] xo [N], output bit wv, output int win,
                       output bit to, output int it, output int lat);
    logic [31:0] acc, sv, dd, t;
    int nzc;
    win = 0; wv = 0; to = 0; it = 0; lat = 1;
    for (int k = 0; k < N; k++) xo[k] = din[k][31] ? 32'd0 : din[k];
    forever begin
      acc = 0; nzc = 0;
      for (int k = 0; k < N; k++)
        if (xo[k] != 0) begin
          nzc++; win = k;
          acc = (acc == 0) ? xo[k] : fadd(acc, xo[k]);
        end
      lat += N;
      if (nzc <= 1) begin
        wv = (nzc == 1);
        break;
      end
      sv = acc;
      for (int i = 0; i < N; i++)
        if (xo[i] != 0) begin
          dd = fadd(sv, {~xo[i][31], xo[i][30:0]});
          t = fmul(e, dd);
          if (t != 0) begin
            if (t[30:0] >= xo[i][30:0]) xo[i] = 0;
            else xo[i] = fadd(xo[i], {1'b1, t[30:0]});
          end
        end
      lat += N + nzc;
      it++;
      if (it == maxit) begin
        to = 1; wv = 0;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input bit sel4, input logic [31:0] din [N],
                     input logic [31:0] e, input int inj_at);
    logic [31:0] xm [N];
    logic [N*XLEN-1:0] vals, vexp;
    bit wvm, tom, got;
    int wm, itm, latm, lat;
    model(din, e, sel4 ? 4 : 64, xm, wvm, wm, tom, itm, latm);
    for (int k = 0; k < N; k++) begin
      data_in[k*XLEN +: XLEN] = din[k];
      vexp[k*XLEN +: XLEN] = xm[k];
    end
    eps = e;
    if (sel4) start4 = 1'b1; else start = 1'b1;
    lat = 0; got = 0;
    while (!got && lat < 3000) begin
      @(posedge clk); #1;
      start = 1'b0; start4 = 1'b0;
      lat++;
      if (inj_at != 0 && lat == inj_at) begin
        data_in = {N{32'h40400000}};
        if (sel4) start4 = 1'b1; else start = 1'b1;
      end
      got = sel4 ? done4 : done;
    end
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_latency"}, lat, latm);
    vals = sel4 ? values4 : values;
    for (int k = 0; k < N; k++)
      check($sformatf("%s_x%0d", tag, k), vals[k*XLEN +: XLEN], xm[k]);
    check({tag, "_winner_valid"}, sel4 ? winner_valid4 : winner_valid, wvm);
    if (wvm) check({tag, "_winner"}, sel4 ? winner4 : winner, wm);
    check({tag, "_timeout"}, sel4 ? timeout4 : timeout, tom);
    check({tag, "_iter_count"}, sel4 ? iter_count4 : iter_count, itm);
    check({tag, "_busy_in_fin"}, sel4 ? busy4 : busy, 1);
    @(posedge clk); #1;
    check({tag, "_done_pulse_end"}, sel4 ? done4 : done, 0);
    check({tag, "_busy_end"}, sel4 ? busy4 : busy, 0);
    check({tag, "_values_hold"}, sel4 ? values4 : values, vexp);
  endtask

  function automatic logic [31:0] rand_word();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel < 2) return 32'd0;
    if (sel == 2) return {1'b1, 8'd126, 23'($urandom)};
    return {1'b0, 8'(124 + $urandom_range(0, 4)), 23'($urandom)};
  endfunction

  initial begin
    logic [31:0] dv [N];
    logic [31:0] ev;
    bit saw_done;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_values", values, 0);
    check("reset_winner", {winner_valid, winner}, 0);
    check("reset_iter_timeout", {timeout, iter_count}, 0);
    check("reset_operands", {add_a, add_b, mul_a, mul_b}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    dv = '{32'h3F800000, 32'h3F000000, 32'h0, 32'h0};
    run("converge", 1'b0, dv, 32'h3E800000, 0);
    check("converge_const_x0", values[31:0], 32'h3F4E0000);
    check("converge_const_iter", iter_count, 3);

    dv = '{32'h0, 32'h0, 32'h40000000, 32'h0};
    add_used = 0;
    run("single", 1'b0, dv, 32'h3E800000, 0);
    check("single_winner_const", winner, 2);
    check("single_adder_unused", add_used, 0);

    dv = '{32'hBF800000, 32'h0, 32'h0, 32'h0};
    run("allneg", 1'b0, dv, 32'h3E800000, 0);
    check("allneg_wv_const", winner_valid, 0);

    dv = '{32'hBF800000, 32'h3F000000, 32'h0, 32'h0};
    run("negclamp", 1'b0, dv, 32'h3E800000, 0);
    check("negclamp_winner_const", winner, 1);

    dv = '{32'h3F800000, 32'h3F800000, 32'h0, 32'h0};
    run("tie", 1'b1, dv, 32'h3E800000, 0);
    check("tie_const_x0", values4[31:0], 32'h3EA20000);
    check("tie_const_x1", values4[63:32], 32'h3EA20000);
    check("tie_const_flags", {timeout4, winner_valid4, iter_count4}, {1'b1, 1'b0, 8'd4});

    dv = '{32'h3F800000, 32'h3F000000, 32'h0, 32'h0};
    for (int k = 0; k < N; k++) data_in[k*XLEN +: XLEN] = dv[k];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_values", values, 0);
    check("midrst_winner", {winner_valid, winner}, 0);
    check("midrst_iter_timeout", {timeout, iter_count}, 0);
    check("midrst_operands", {add_a, add_b, mul_a, mul_b}, 0);
    saw_done = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    check("midrst_no_done", saw_done, 0);
    run("after_reset", 1'b0, dv, 32'h3E800000, 0);

    dv = '{32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h0};
    run("start_busy", 1'b0, dv, 32'h3E800000, N + 2);

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < N; k++) dv[k] = rand_word();
      ev = {1'b0, 8'(123 + $urandom_range(0, 2)), 23'($urandom)};
      run($sformatf("rand%0d", r), 1'b0, dv, ev, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
